// File: rtl/lmsm_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : lmsm_sequencer
//  Description : Decode-stage expander that turns one LM/SM instruction into
//                NUM_SLOTS slot-tagged micro-ops while holding IF/ID.
//  Revision    : 1.0 - initial release
// ============================================================================
module lmsm_sequencer #(
    parameter int         NUM_SLOTS = 7,
    parameter int         K_W       = 3,
    parameter logic [3:0] OPC_LM    = 4'b1100,
    parameter logic [3:0] OPC_SM    = 4'b1101
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [15:0]    instr_id,
    input  logic           instr_valid,
    input  logic           pipe_stall,
    input  logic           flush,
    output logic           uop_valid,
    output logic [K_W-1:0] k_out,
    output logic [2:0]     reg_addr,
    output logic [15:0]    mem_offset,
    output logic           last_uop,
    output logic           fetch_stall,
    output logic           lmsm_active
);

    localparam logic [0:0]     c_st_idle = 1'b0;
    localparam logic [0:0]     c_st_seq  = 1'b1;
    localparam logic [K_W-1:0] c_k_last  = K_W'(NUM_SLOTS - 1);
    localparam logic [K_W-1:0] c_k_one   = K_W'(1);

    logic [0:0]     r_state;
    logic [0:0]     w_state_nxt;
    logic [K_W-1:0] r_k;
    logic [K_W-1:0] w_k_nxt;
    logic [K_W-1:0] w_k_cur;
    logic [K_W-1:0] w_slot_rev;
    logic           w_is_lmsm;
    logic           w_unused_imm;

    assign w_is_lmsm = instr_valid &&
                       ((instr_id[15:12] == OPC_LM) || (instr_id[15:12] == OPC_SM));

    // Expansion is dense: the register list is applied by the MEM-stage mask,
    // so the immediate field is intentionally not consulted here.
    assign w_unused_imm = ^instr_id[11:0];

    // Slot 0 is issued from IDLE, so entering SEQ starts at slot 1.
    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        if (flush) begin
            w_state_nxt = c_st_idle;
            w_k_nxt     = '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_is_lmsm && !pipe_stall) begin
                        w_state_nxt = c_st_seq;
                        w_k_nxt     = c_k_one;
                    end
                end
                c_st_seq: begin
                    if (!pipe_stall) begin
                        if (r_k == c_k_last) begin
                            w_state_nxt = c_st_idle;
                            w_k_nxt     = '0;
                        end else begin
                            w_k_nxt = r_k + c_k_one;
                        end
                    end
                end
                default: begin
                    w_state_nxt = c_st_idle;
                    w_k_nxt     = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
            r_k     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
        end
    end

    always_comb begin
        uop_valid   = instr_valid;
        w_k_cur     = '0;
        last_uop    = 1'b0;
        fetch_stall = w_is_lmsm;
        lmsm_active = 1'b0;
        if (r_state == c_st_seq) begin
            uop_valid   = 1'b1;
            w_k_cur     = r_k;
            last_uop    = (r_k == c_k_last);
            fetch_stall = (r_k != c_k_last);
            lmsm_active = 1'b1;
        end
    end

    // Slots walk the register file from the top down while offsets climb.
    assign w_slot_rev = c_k_last - w_k_cur;
    assign k_out      = w_k_cur;
    assign reg_addr   = 3'(w_slot_rev);
    assign mem_offset = 16'(w_k_cur);

endmodule
`default_nettype wire

// File: tb/tb_lmsm_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lmsm_sequencer
//  Description : Directed-vector bench with a queue-based scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lmsm_sequencer;

    logic        clk;
    logic        rst_n;
    logic [15:0] instr_id;
    logic        instr_valid;
    logic        pipe_stall;
    logic        flush;
    logic        uop_valid;
    logic [2:0]  k_out;
    logic [2:0]  reg_addr;
    logic [15:0] mem_offset;
    logic        last_uop;
    logic        fetch_stall;
    logic        lmsm_active;

    lmsm_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr_id   (instr_id),
        .instr_valid(instr_valid),
        .pipe_stall (pipe_stall),
        .flush      (flush),
        .uop_valid  (uop_valid),
        .k_out      (k_out),
        .reg_addr   (reg_addr),
        .mem_offset (mem_offset),
        .last_uop   (last_uop),
        .fetch_stall(fetch_stall),
        .lmsm_active(lmsm_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       care;
        logic       uv;
        logic [2:0] k;
        logic       fs;
        logic       last;
        logic       act;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    event ev_sample;

    localparam logic [15:0] c_lm  = 16'hC053;
    localparam logic [15:0] c_sm  = 16'hD07F;
    localparam logic [15:0] c_add = 16'h0000;

    task automatic chk(input string name, input int actual, input int required);
        n_checks++;
        if (actual != required) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, actual, required, $time);
        end
    endtask

    task automatic push(input logic care, input logic uv, input logic [2:0] k,
                        input logic fs, input logic last, input logic act);
        exp_t e;
        e.care = care; e.uv = uv; e.k = k; e.fs = fs; e.last = last; e.act = act;
        sb_q.push_back(e);
    endtask

    // Drive one cycle of inputs just after the edge and queue what it must produce.
    task automatic cyc(input logic v, input logic [15:0] ins, input logic st, input logic fl,
                       input logic care, input logic uv, input logic [2:0] k,
                       input logic fs, input logic last, input logic act);
        @(posedge clk);
        #1;
        instr_valid = v;
        instr_id    = ins;
        pipe_stall  = st;
        flush       = fl;
        push(care, uv, k, fs, last, act);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk or ev_sample);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                if (e.care) begin
                    chk("uop_valid",   int'(uop_valid),   int'(e.uv));
                    chk("k_out",       int'(k_out),       int'(e.k));
                    chk("reg_addr",    int'(reg_addr),    6 - int'(e.k));
                    chk("mem_offset",  int'(mem_offset),  int'(e.k));
                    chk("fetch_stall", int'(fetch_stall), int'(e.fs));
                    chk("last_uop",    int'(last_uop),    int'(e.last));
                    chk("lmsm_active", int'(lmsm_active), int'(e.act));
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr_id    = 16'h0000;
        pipe_stall  = 1'b0;
        flush       = 1'b0;
        #3;
        push(1, 0, 0, 0, 0, 0);
        -> ev_sample;
        @(negedge clk);
        rst_n = 1'b1;

        // Opcode LM but not valid: not a sequence trigger
        cyc(0, c_lm, 0, 0, 1, 0, 0, 0, 0, 0);

        // LM, no stalls
        cyc(1, c_lm, 0, 0, 1, 1, 0, 1, 0, 0);
        for (int k = 1; k <= 5; k++) cyc(1, c_lm, 0, 0, 1, 1, 3'(k), 1, 0, 1);
        cyc(1, c_lm, 0, 0, 1, 1, 6, 0, 1, 1);

        // Plain ADD passes straight through
        for (int i = 0; i < 3; i++) cyc(1, c_add, 0, 0, 1, 1, 0, 0, 0, 0);

        // SM with stall on the k=3 cycle and the one after
        cyc(1, c_sm, 0, 0, 1, 1, 0, 1, 0, 0);
        cyc(1, c_sm, 0, 0, 1, 1, 1, 1, 0, 1);
        cyc(1, c_sm, 0, 0, 1, 1, 2, 1, 0, 1);
        cyc(1, c_sm, 1, 0, 1, 1, 3, 1, 0, 1);
        cyc(1, c_sm, 1, 0, 1, 1, 3, 1, 0, 1);
        cyc(1, c_sm, 0, 0, 1, 1, 3, 1, 0, 1);
        cyc(1, c_sm, 0, 0, 1, 1, 4, 1, 0, 1);
        cyc(1, c_sm, 0, 0, 1, 1, 5, 1, 0, 1);
        cyc(1, c_sm, 0, 0, 1, 1, 6, 0, 1, 1);

        // LM stalled in IDLE re-presents slot 0, then flush at k=4
        cyc(1, c_lm, 1, 0, 1, 1, 0, 1, 0, 0);
        cyc(1, c_lm, 0, 0, 1, 1, 0, 1, 0, 0);
        for (int k = 1; k <= 3; k++) cyc(1, c_lm, 0, 0, 1, 1, 3'(k), 1, 0, 1);
        cyc(1, c_lm, 0, 1, 0, 1, 4, 1, 0, 1);
        cyc(1, c_add, 0, 0, 1, 1, 0, 0, 0, 0);

        // Flush while an LM waits in IDLE keeps it in IDLE; then LM+SM back-to-back
        cyc(1, c_lm, 0, 1, 0, 1, 0, 1, 0, 0);
        cyc(1, c_lm, 0, 0, 1, 1, 0, 1, 0, 0);
        for (int k = 1; k <= 5; k++) cyc(1, c_lm, 0, 0, 1, 1, 3'(k), 1, 0, 1);
        cyc(1, c_lm, 0, 0, 1, 1, 6, 0, 1, 1);
        cyc(1, c_sm, 0, 0, 1, 1, 0, 1, 0, 0);
        for (int k = 1; k <= 5; k++) cyc(1, c_sm, 0, 0, 1, 1, 3'(k), 1, 0, 1);
        cyc(1, c_sm, 0, 0, 1, 1, 6, 0, 1, 1);
        cyc(0, c_add, 0, 0, 1, 0, 0, 0, 0, 0);

        // Asynchronous reset in the middle of an LM at k=2
        cyc(1, c_lm, 0, 0, 1, 1, 0, 1, 0, 0);
        cyc(1, c_lm, 0, 0, 1, 1, 1, 1, 0, 1);
        cyc(1, c_lm, 0, 0, 1, 1, 2, 1, 0, 1);
        @(negedge clk);
        #2;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        #1;
        push(1, 0, 0, 0, 0, 0);
        -> ev_sample;
        @(posedge clk);
        #1;
        push(1, 0, 0, 0, 0, 0);
        -> ev_sample;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        cyc(0, c_lm, 0, 0, 1, 0, 0, 0, 0, 0);
        cyc(1, c_lm, 0, 0, 1, 1, 0, 1, 0, 0);
        cyc(1, c_lm, 0, 0, 1, 1, 1, 1, 0, 1);

        repeat (2) @(negedge clk);
        #1;
        chk("scoreboard_drain", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
